// File: rtl/pc_ctrl.sv
// Program-counter and branch-control stage: flag register, BRZ/BRN/JMP resolution, IDLE/RUN/FLUSH/HALT sequencing.
// Optional taken-branch counter output br_count enabled by defining PC_CTRL_BRCOUNT_EN.
module pc_ctrl #(
    parameter int PC_W       = 10,
    parameter int OFF_W      = 8,
    parameter int START_ADDR = 0
) (
    input  logic             CLK,
    input  logic             reset_n,
    input  logic             start,
    input  logic             alu_z,
    input  logic             alu_neg,
    input  logic             alu_co,
    input  logic             flag_we,
    input  logic             br_valid,
    input  logic [1:0]       br_type,
    input  logic [OFF_W-1:0] br_off,
    input  logic [PC_W-1:0]  br_target,
    input  logic             stall,
    input  logic             halt_req,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_valid,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             taken,
    output logic             halted
`ifdef PC_CTRL_BRCOUNT_EN
    ,
    output logic [15:0]      br_count
`endif
);

    localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_HALT
    } state_t;

    state_t          r_state;
    state_t          w_stateNext;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pcNext;
    logic [PC_W-1:0] w_offExt;
    logic [PC_W-1:0] w_target;
    logic            r_flagZ;
    logic            r_flagN;
    logic            r_flagC;
    logic            r_taken;
    logic            r_halted;
    logic            w_takenNext;
    logic            w_cond;
    logic            w_flagLoad;
    logic            w_startAccept;

    // Branch decisions only ever see the registered flags, never this cycle's ALU flags.
    assign w_offExt = PC_W'($signed(br_off));
    assign w_target = (br_type == 2'b11) ? br_target : (r_pc + w_offExt);

    always_comb begin
        w_cond = 1'b0;
        case (br_type)
            2'b01:   w_cond = r_flagZ;
            2'b10:   w_cond = r_flagN;
            2'b11:   w_cond = 1'b1;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_stateNext = r_state;
        w_pcNext    = r_pc;
        w_takenNext = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_stateNext = S_RUN;
                    w_pcNext    = START_PC;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (halt_req) begin
                        w_stateNext = S_HALT;
                    end else if (br_valid && w_cond) begin
                        w_stateNext = S_FLUSH;
                        w_pcNext    = w_target;
                        w_takenNext = 1'b1;
                    end else begin
                        w_pcNext = r_pc + PC_W'(1);
                    end
                end
            end
            S_FLUSH: begin
                if (!stall) begin
                    w_stateNext = halt_req ? S_HALT : S_RUN;
                end
            end
            S_HALT: begin
                if (start) begin
                    w_stateNext = S_RUN;
                    w_pcNext    = START_PC;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_pcNext    = START_PC;
            end
        endcase
    end

    assign w_flagLoad    = flag_we && ((r_state == S_RUN) || (r_state == S_FLUSH));
    assign w_startAccept = start && ((r_state == S_IDLE) || (r_state == S_HALT));

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_pc     <= START_PC;
            r_taken  <= 1'b0;
            r_halted <= 1'b0;
        end else begin
            r_state  <= w_stateNext;
            r_pc     <= w_pcNext;
            r_taken  <= w_takenNext;
            r_halted <= (w_stateNext == S_HALT);
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset_n) begin
            r_flagZ <= 1'b0;
            r_flagN <= 1'b0;
            r_flagC <= 1'b0;
        end else if (w_flagLoad) begin
            r_flagZ <= alu_z;
            r_flagN <= alu_neg;
            r_flagC <= alu_co;
        end
    end

`ifdef PC_CTRL_BRCOUNT_EN
    logic [15:0] r_brCount;

    always_ff @(posedge CLK) begin
        if (!reset_n || w_startAccept) begin
            r_brCount <= 16'h0000;
        end else if (w_takenNext && (r_brCount != 16'hFFFF)) begin
            r_brCount <= r_brCount + 16'h0001;
        end
    end

    assign br_count = r_brCount;
`else
    logic w_unusedStart;
    assign w_unusedStart = w_startAccept;
`endif

    assign pc          = r_pc;
    assign fetch_valid = (r_state == S_RUN);
    assign flag_z      = r_flagZ;
    assign flag_n      = r_flagN;
    assign flag_c      = r_flagC;
    assign taken       = r_taken;
    assign halted      = r_halted;

endmodule

// File: tb/tb_pc_ctrl.sv
// Self-checking bench for pc_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_ctrl;

    localparam int PC_W    = 10;
    localparam int PC_MASK = (1 << PC_W) - 1;
    localparam int START   = 0;

    localparam int MODE_IDLE  = 0;
    localparam int MODE_RUN   = 1;
    localparam int MODE_FLUSH = 2;
    localparam int MODE_HALT  = 3;

    logic            clk = 1'b0;
    logic            resetN;
    logic            start;
    logic            aluZ;
    logic            aluNeg;
    logic            aluCo;
    logic            flagWe;
    logic            brValid;
    logic [1:0]      brType;
    logic [7:0]      brOff;
    logic [PC_W-1:0] brTarget;
    logic            stall;
    logic            haltReq;
    logic [PC_W-1:0] pc;
    logic            fetchValid;
    logic            flagZ;
    logic            flagN;
    logic            flagC;
    logic            taken;
    logic            halted;
`ifdef PC_CTRL_BRCOUNT_EN
    logic [15:0]     brCount;
`endif

    int mMode;
    int mPc;
    bit mZ;
    bit mN;
    bit mC;
    bit mTaken;
    bit mHalted;
    int mCount;

    int checks = 0;
    int errors = 0;

    pc_ctrl #(.PC_W(PC_W), .OFF_W(8), .START_ADDR(START)) dut (
        .CLK        (clk),
        .reset_n    (resetN),
        .start      (start),
        .alu_z      (aluZ),
        .alu_neg    (aluNeg),
        .alu_co     (aluCo),
        .flag_we    (flagWe),
        .br_valid   (brValid),
        .br_type    (brType),
        .br_off     (brOff),
        .br_target  (brTarget),
        .stall      (stall),
        .halt_req   (haltReq),
        .pc         (pc),
        .fetch_valid(fetchValid),
        .flag_z     (flagZ),
        .flag_n     (flagN),
        .flag_c     (flagC),
        .taken      (taken),
        .halted     (halted)
`ifdef PC_CTRL_BRCOUNT_EN
        ,
        .br_count   (brCount)
`endif
    );

    always #5 clk = ~clk;

    // Advance the model by one clock from the current inputs, clock the DUT, then clear one-shot inputs.
    task automatic step();
        bit cond;
        bit loadFlags;
        int off;
        mTaken = 1'b0;
        if (!resetN) begin
            mMode = MODE_IDLE;
            mPc = START;
            mZ = 0; mN = 0; mC = 0;
            mCount = 0;
        end else begin
            loadFlags = flagWe && (mMode == MODE_RUN || mMode == MODE_FLUSH);
            case (mMode)
                MODE_IDLE, MODE_HALT: begin
                    if (start) begin
                        mMode = MODE_RUN;
                        mPc = START;
                        mCount = 0;
                    end
                end
                MODE_RUN: begin
                    if (stall) begin
                    end else if (haltReq) begin
                        mMode = MODE_HALT;
                    end else begin
                        cond = brValid && ((brType == 2'd1 && mZ) || (brType == 2'd2 && mN) || brType == 2'd3);
                        if (cond) begin
                            off = $signed(brOff);
                            mPc = (brType == 2'd3) ? int'(brTarget) : ((mPc + off) & PC_MASK);
                            mTaken = 1'b1;
                            mMode = MODE_FLUSH;
                            if (mCount < 65535) mCount++;
                        end else begin
                            mPc = (mPc + 1) & PC_MASK;
                        end
                    end
                end
                default: begin
                    if (!stall) mMode = haltReq ? MODE_HALT : MODE_RUN;
                end
            endcase
            if (loadFlags) begin
                mZ = aluZ; mN = aluNeg; mC = aluCo;
            end
        end
        mHalted = (mMode == MODE_HALT);
        @(posedge clk);
        #1;
        start = 0; flagWe = 0; brValid = 0; stall = 0; haltReq = 0;
    endtask

    task automatic test_reset();
        resetN = 0;
        step();
        checks++; if (pc !== 10'd0) begin errors++; $display("[TB] FAIL reset_pc actual=%0d expected=0", pc); end
        checks++; if (fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_fv actual=%b expected=0", fetchValid); end
        checks++; if ({flagZ, flagN, flagC} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags actual=%b%b%b expected=000", flagZ, flagN, flagC); end
        checks++; if (taken !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_taken_halted actual=%b%b expected=00", taken, halted); end
        resetN = 1;
        step();
        checks++; if (fetchValid !== 1'b0 || pc !== 10'd0) begin errors++; $display("[TB] FAIL idle_hold actual fv=%b pc=%0d expected fv=0 pc=0", fetchValid, pc); end
    endtask

    task automatic test_sequential();
        start = 1;
        step();
        checks++; if (pc !== 10'd0 || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL start_pc actual pc=%0d fv=%b expected pc=0 fv=1", pc, fetchValid); end
        for (int i = 1; i <= 3; i++) begin
            if (i == 2) start = 1;
            step();
            checks++; if (pc !== PC_W'(i) || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL seq_pc%0d actual pc=%0d fv=%b expected pc=%0d fv=1", i, pc, fetchValid, i); end
        end
    endtask

    task automatic test_brz();
        step();
        flagWe = 1; aluZ = 1; aluNeg = 0; aluCo = 0;
        step();
        checks++; if (pc !== 10'd5 || flagZ !== 1'b1) begin errors++; $display("[TB] FAIL brz_setup actual pc=%0d z=%b expected pc=5 z=1", pc, flagZ); end
        brValid = 1; brType = 2'b01; brOff = 8'hFE;
        step();
        checks++; if (pc !== 10'd3 || taken !== 1'b1 || fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL brz_taken actual pc=%0d taken=%b fv=%b expected pc=3 taken=1 fv=0", pc, taken, fetchValid); end
        step();
        checks++; if (pc !== 10'd3 || taken !== 1'b0 || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL brz_flush_end actual pc=%0d taken=%b fv=%b expected pc=3 taken=0 fv=1", pc, taken, fetchValid); end
        flagWe = 1; aluZ = 0;
        step();
        step();
        brValid = 1; brType = 2'b01; brOff = 8'hFE;
        step();
        checks++; if (pc !== 10'd6 || taken !== 1'b0 || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL brz_not_taken actual pc=%0d taken=%b fv=%b expected pc=6 taken=0 fv=1", pc, taken, fetchValid); end
    endtask

    task automatic test_same_cycle_flag();
        flagWe = 1; aluNeg = 1; aluZ = 0; aluCo = 0;
        brValid = 1; brType = 2'b10; brOff = 8'd4;
        step();
        checks++; if (pc !== 10'd7 || taken !== 1'b0 || flagN !== 1'b1) begin errors++; $display("[TB] FAIL brn_same_cycle actual pc=%0d taken=%b n=%b expected pc=7 taken=0 n=1", pc, taken, flagN); end
        brValid = 1; brType = 2'b10; brOff = 8'd4;
        step();
        checks++; if (pc !== 10'd11 || taken !== 1'b1) begin errors++; $display("[TB] FAIL brn_next_cycle actual pc=%0d taken=%b expected pc=11 taken=1", pc, taken); end
        step();
    endtask

    task automatic test_wrap();
        brValid = 1; brType = 2'b11; brTarget = 10'd1020;
        step();
        checks++; if (pc !== 10'd1020 || taken !== 1'b1) begin errors++; $display("[TB] FAIL jmp_abs actual pc=%0d taken=%b expected pc=1020 taken=1", pc, taken); end
        flagWe = 1; aluZ = 1; aluNeg = 1; aluCo = 0;
        step();
        checks++; if (flagZ !== 1'b1 || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL flush_flag_load actual z=%b fv=%b expected z=1 fv=1", flagZ, fetchValid); end
        step();
        brValid = 1; brType = 2'b01; brOff = 8'd5;
        step();
        checks++; if (pc !== 10'd2 || taken !== 1'b1) begin errors++; $display("[TB] FAIL brz_wrap actual pc=%0d taken=%b expected pc=2 taken=1", pc, taken); end
        step();
        brValid = 1; brType = 2'b11; brTarget = 10'd1023;
        step();
        step();
        step();
        checks++; if (pc !== 10'd0 || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL inc_wrap actual pc=%0d fv=%b expected pc=0 fv=1", pc, fetchValid); end
    endtask

    task automatic test_stall_halt();
        for (int i = 0; i < 3; i++) begin
            stall = 1; brValid = 1; brType = 2'b11; brTarget = 10'd500;
            if (i == 0) begin flagWe = 1; aluZ = 1; aluNeg = 1; aluCo = 1; end
            step();
            checks++; if (pc !== 10'd0 || taken !== 1'b0 || fetchValid !== 1'b1) begin errors++; $display("[TB] FAIL stall%0d actual pc=%0d taken=%b fv=%b expected pc=0 taken=0 fv=1", i, pc, taken, fetchValid); end
        end
        checks++; if (flagC !== 1'b1) begin errors++; $display("[TB] FAIL stall_flag_we actual c=%b expected 1", flagC); end
        haltReq = 1; brValid = 1; brType = 2'b11; brTarget = 10'd500;
        step();
        checks++; if (pc !== 10'd0 || halted !== 1'b1 || fetchValid !== 1'b0 || taken !== 1'b0) begin errors++; $display("[TB] FAIL halt_entry actual pc=%0d halted=%b fv=%b taken=%b expected pc=0 halted=1 fv=0 taken=0", pc, halted, fetchValid, taken); end
        flagWe = 1; aluZ = 0; aluNeg = 0; aluCo = 0;
        step();
        checks++; if ({flagZ, flagN, flagC} !== 3'b111 || halted !== 1'b1) begin errors++; $display("[TB] FAIL halt_frozen actual flags=%b%b%b halted=%b expected flags=111 halted=1", flagZ, flagN, flagC, halted); end
        start = 1;
        step();
        checks++; if (pc !== 10'd0 || fetchValid !== 1'b1 || halted !== 1'b0 || {flagZ, flagN, flagC} !== 3'b111) begin errors++; $display("[TB] FAIL halt_restart actual pc=%0d fv=%b halted=%b flags=%b%b%b expected pc=0 fv=1 halted=0 flags=111", pc, fetchValid, halted, flagZ, flagN, flagC); end
        step();
    endtask

    task automatic test_reset_flush();
        brValid = 1; brType = 2'b11; brTarget = 10'd100;
        step();
        checks++; if (pc !== 10'd100 || fetchValid !== 1'b0) begin errors++; $display("[TB] FAIL flush_before_reset actual pc=%0d fv=%b expected pc=100 fv=0", pc, fetchValid); end
        resetN = 0;
        step();
        checks++; if (pc !== 10'd0 || fetchValid !== 1'b0 || {flagZ, flagN, flagC} !== 3'b000 || taken !== 1'b0 || halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_flush actual pc=%0d fv=%b flags=%b%b%b taken=%b halted=%b expected all zero", pc, fetchValid, flagZ, flagN, flagC, taken, halted); end
        resetN = 1;
        step();
        checks++; if (fetchValid !== 1'b0 || pc !== 10'd0) begin errors++; $display("[TB] FAIL idle_after_reset actual fv=%b pc=%0d expected fv=0 pc=0", fetchValid, pc); end
    endtask

`ifdef PC_CTRL_BRCOUNT_EN
    task automatic test_brcount();
        start = 1;
        step();
        for (int i = 1; i <= 4; i++) begin
            brValid = 1; brType = 2'b11; brTarget = PC_W'(i * 10);
            step();
            step();
        end
        checks++; if (brCount !== 16'd4) begin errors++; $display("[TB] FAIL brcount_four actual=%0d expected=4", brCount); end
        resetN = 0;
        step();
        checks++; if (brCount !== 16'd0) begin errors++; $display("[TB] FAIL brcount_reset actual=%0d expected=0", brCount); end
        resetN = 1;
    endtask
`endif

    task automatic test_random();
        resetN = 1;
        for (int n = 0; n < 600; n++) begin
            resetN   = ($urandom_range(63) != 0);
            start    = ($urandom_range(7) == 0);
            flagWe   = $urandom_range(1);
            aluZ     = $urandom_range(1);
            aluNeg   = $urandom_range(1);
            aluCo    = $urandom_range(1);
            brValid  = ($urandom_range(2) == 0);
            brType   = 2'($urandom_range(3));
            brOff    = 8'($urandom);
            brTarget = PC_W'($urandom);
            stall    = ($urandom_range(4) == 0);
            haltReq  = ($urandom_range(15) == 0);
            step();
            checks++;
            if (pc !== PC_W'(mPc) || fetchValid !== (mMode == MODE_RUN) || flagZ !== mZ || flagN !== mN ||
                flagC !== mC || taken !== mTaken || halted !== mHalted) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d actual pc=%0d fv=%b znc=%b%b%b taken=%b halted=%b expected pc=%0d fv=%b znc=%b%b%b taken=%b halted=%b",
                         n, pc, fetchValid, flagZ, flagN, flagC, taken, halted,
                         mPc, (mMode == MODE_RUN), mZ, mN, mC, mTaken, mHalted);
            end
`ifdef PC_CTRL_BRCOUNT_EN
            checks++;
            if (brCount !== 16'(mCount)) begin
                errors++;
                $display("[TB] FAIL random_brcount%0d actual=%0d expected=%0d", n, brCount, mCount);
            end
`endif
        end
        resetN = 1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resetN = 0; start = 0; aluZ = 0; aluNeg = 0; aluCo = 0; flagWe = 0;
        brValid = 0; brType = 2'b00; brOff = 8'd0; brTarget = '0; stall = 0; haltReq = 0;
        mMode = MODE_IDLE; mPc = START; mZ = 0; mN = 0; mC = 0; mTaken = 0; mHalted = 0; mCount = 0;
        test_reset();
        test_sequential();
        test_brz();
        test_same_cycle_flag();
        test_wrap();
        test_stall_halt();
        test_reset_flush();
`ifdef PC_CTRL_BRCOUNT_EN
        test_brcount();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
Program-counter and branch-control stage, directly downstream of the ALU.
- Registers the ALU's z/neg/co flags into a flag register.
- Resolves BRZ/BRN (relative) and JMP (absolute) branches against the registered flags.
- Sequences the PC through start, run, branch-flush and halt.
- Drives the instruction-memory address and a fetch_valid qualifier to the fetch/decode logic.

Parameters:
PC_W, 10, program counter width in bits; PC arithmetic is modulo 2^PC_W
OFF_W, 8, width of the signed two's-complement relative branch offset (OFF_W <= PC_W)
START_ADDR, 0, PC value loaded on reset and on start

Ports:
CLK  in  1  clock; all state updates on rising edge
reset_n  in  1  synchronous active-low reset
start  in  1  one-cycle pulse; begins execution from START_ADDR
alu_z  in  1  ALU zero flag
alu_neg  in  1  ALU negative flag
alu_co  in  1  ALU carry-out
flag_we  in  1  latch alu_z/alu_neg/alu_co into the flag register this cycle
br_valid  in  1  current instruction is a branch/jump
br_type  in  2  00 none, 01 BRZ, 10 BRN, 11 JMP
br_off  in  OFF_W  signed relative offset for BRZ/BRN
br_target  in  PC_W  absolute target for JMP
stall  in  1  hold PC and state; branch inputs ignored
halt_req  in  1  stop execution after the current instruction
pc  out  PC_W  instruction address
fetch_valid  out  1  pc addresses an instruction to be executed this cycle
flag_z  out  1  registered zero flag
flag_n  out  1  registered negative flag
flag_c  out  1  registered carry flag
taken  out  1  one-cycle pulse: a branch was taken this cycle
halted  out  1  high while in HALT

Behaviour:
Reset (reset_n=0 at an edge):
- state=IDLE, pc=START_ADDR, all flags=0, taken=0, halted=0, fetch_valid=0.
- Reset overrides every other input, including mid-FLUSH and in HALT.

States: IDLE, RUN, FLUSH, HALT.
- IDLE: pc holds START_ADDR; fetch_valid=0. start=1 -> RUN, pc=START_ADDR.
- RUN: fetch_valid=1. Priority each cycle, highest first:
  - stall=1 -> hold everything. flag_we is still honoured.
  - halt_req=1 -> HALT; pc holds; br_valid ignored.
  - br_valid=1 with condition true -> pc=target; taken=1 for that cycle; next state FLUSH.
  - otherwise -> pc=pc+1.
- Branch conditions:
  - BRZ is true if flag_z=1.
  - BRN is true if flag_n=1.
  - JMP is always true.
  - br_type=00 with br_valid=1 is treated as not taken.
- Conditions use the registered flags only. A flag_we in the same cycle as br_valid does not affect that branch; the new flags are visible from the next cycle.
- FLUSH: exactly one cycle.
  - fetch_valid=0, so the decoder discards the instruction fetched at the old pc+1.
  - pc holds the target.
  - Next state RUN, with the target now fetch_valid.
  - stall in FLUSH extends FLUSH. halt_req in FLUSH -> HALT.
- HALT: pc and flags frozen; fetch_valid=0; halted=1. start=1 -> RUN from START_ADDR with flags preserved.
- start is ignored in RUN and FLUSH.

Arithmetic:
- Relative target = pc + sign_extend(br_off), modulo 2^PC_W.
- Absolute target = br_target.
- Sequential increment wraps (2^PC_W)-1 -> 0 with no error indication.
- br_off=0 is a legal self-loop.

Flag register:
- Loads on flag_we in any state except IDLE and HALT.
- Holds otherwise.

Outputs:
- All outputs are registered except fetch_valid, which is decoded from state.
- taken is high only in the cycle the pc register is loaded with a branch target.

Optional Feature:
Macro PC_CTRL_BRCOUNT_EN.
- Defined:
  - Adds output br_count (16 bits): number of taken branches since reset or start.
  - Increments with taken and saturates at 16'hFFFF.
  - Cleared by reset_n=0 and by a start accepted from IDLE or HALT.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
1. Reset then start -> pc=0, 1, 2, 3 on successive cycles; fetch_valid=1 from the cycle after start; flags=0.
2. flag_we with alu_z=1, next cycle BRZ with br_off=-2 at pc=5 -> pc=3, taken=1 for one cycle; next cycle fetch_valid=0 (FLUSH); then pc=3 with fetch_valid=1. Same BRZ with flag_z=0 -> pc=6, taken=0.
3. Same-cycle flag_we (alu_neg=1) and BRN while flag_n=0 -> not taken, pc+1. BRN on the following cycle -> taken.
4. PC_W=10, pc=1023 -> next pc=0. JMP br_target=1020 at pc=2 -> pc=1020. BRZ br_off=+5 at pc=1021 with flag_z=1 -> pc=2.
5. stall for 3 cycles with br_valid=1 -> pc unchanged and no taken. halt_req together with a JMP -> HALT, pc unchanged, halted=1. start -> pc=START_ADDR, flags retained.
6. reset_n=0 during FLUSH -> next cycle IDLE, pc=START_ADDR, flags=0. With PC_CTRL_BRCOUNT_EN, 4 taken branches -> br_count=4; after reset -> 0.
